adsr_envelope: RTL and testbench

//   Downstream of the oscillator. Applies an ADSR (attack/decay/sustain/release) amplitude envelope to its 16-bit signed

---
 rtl/adsr_envelope_if.sv | 22 ++
 rtl/adsr_envelope.sv | 111 +++++++++++
 tb/tb_adsr_envelope.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adsr_envelope_if.sv
// Control and sample signals between the note/voice controller and the ADSR envelope.
interface adsr_envelope_if;
    logic               gate;
    logic        [15:0] attack_rate;
    logic        [15:0] decay_rate;
    logic        [15:0] sustain_level;
    logic        [15:0] release_rate;
    logic signed [15:0] wave_in;
    logic signed [15:0] wave_out;
    logic        [15:0] env_level;
    logic        [2:0]  env_state;

    modport master (
        output gate, attack_rate, decay_rate, sustain_level, release_rate, wave_in,
        input  wave_out, env_level, env_state
    );

    modport slave (
        input  gate, attack_rate, decay_rate, sustain_level, release_rate, wave_in,
        output wave_out, env_level, env_state
    );
endinterface

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: a five-phase level generator stepped at a prescaled tick,
// and a registered multiply that applies the level to the oscillator sample.
module adsr_envelope #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic           clk,
    input  logic           reset,
    adsr_envelope_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_e;

    localparam int unsigned   CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0]      presc_q, presc_d;
    logic               gate_q;
    state_e             state_q, state_d;
    logic [15:0]        level_q, level_d;
    logic signed [15:0] wave_q, wave_d;

    logic               tick, rise, fall;
    logic [16:0]        att_sum, dec_floor;
    logic signed [32:0] wave_x, level_x, prod;

    assign tick    = (presc_q == TICK_LAST);
    assign presc_d = tick ? '0 : presc_q + 1'b1;
    assign rise    =  bus.gate & ~gate_q;
    assign fall    = ~bus.gate &  gate_q;

    // 17-bit sums so the saturation compares see the carry.
    assign att_sum   = {1'b0, level_q} + {1'b0, bus.attack_rate};
    assign dec_floor = {1'b0, bus.sustain_level} + {1'b0, bus.decay_rate};

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (rise) begin
            state_d = ATTACK;
        end else if (fall) begin
            if (state_q inside {ATTACK, DECAY, SUSTAIN}) state_d = RELEASE;
        end else if (tick) begin
            case (state_q)
                IDLE: level_d = '0;
                ATTACK: begin
                    if (att_sum >= 17'h0FFFF) begin
                        level_d = 16'hFFFF;
                        state_d = DECAY;
                    end else begin
                        level_d = att_sum[15:0];
                    end
                end
                DECAY: begin
                    // Also covers a sustain level at or above the current level on entry.
                    if ({1'b0, level_q} <= dec_floor) begin
                        level_d = bus.sustain_level;
                        state_d = SUSTAIN;
                    end else begin
                        level_d = level_q - bus.decay_rate;
                    end
                end
                SUSTAIN: level_d = bus.sustain_level;
                RELEASE: begin
                    if (level_q <= bus.release_rate) begin
                        level_d = '0;
                        state_d = IDLE;
                    end else begin
                        level_d = level_q - bus.release_rate;
                    end
                end
                default: begin
                    level_d = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Unsigned level widened with a zero MSB so the product stays a signed multiply.
    assign wave_x = 33'(bus.wave_in);
    assign level_x = 33'({1'b0, level_q});
    assign prod    = wave_x * level_x;
    assign wave_d  = 16'(prod >>> 16);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q <= '0;
            gate_q  <= 1'b0;
            state_q <= IDLE;
            level_q <= '0;
            wave_q  <= '0;
        end else begin
            presc_q <= presc_d;
            gate_q  <= bus.gate;
            state_q <= state_d;
            level_q <= level_d;
            wave_q  <= wave_d;
        end
    end

    assign bus.env_state = state_q;
    assign bus.env_level = level_q;
    assign bus.wave_out  = wave_q;
endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed table, hand-written corner sequences,
// then randomized gate/rate/reset traffic against an integer reference model.
module tb_adsr_envelope;
    localparam int TICK_DIV   = 4;
    localparam int ST_IDLE    = 0;
    localparam int ST_ATTACK  = 1;
    localparam int ST_DECAY   = 2;
    localparam int ST_SUSTAIN = 3;
    localparam int ST_RELEASE = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    adsr_envelope_if bus();

    adsr_envelope #(.TICK_DIV(TICK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: phase number, level and prescaler count as plain integers.
    int m_state = 0;
    int m_lvl   = 0;
    int m_cnt   = 0;
    int m_wave  = 0;
    bit m_gprev = 1'b0;

    typedef enum {OP_EDGE, OP_TICK, OP_WAVE} op_e;
    typedef struct {
        op_e         op;
        bit          gate;
        logic [15:0] wave;
        int          st;
        logic [15:0] lvl;
        logic [15:0] wv;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // One clock: predict from the pre-edge inputs, let the edge happen, compare.
    task automatic cyc(output bit ticked);
        int ns, nl, nc, nw, ar, dr, sus, rr;
        bit tick, rise, fall;
        longint p;
        ar   = int'(bus.attack_rate);
        dr   = int'(bus.decay_rate);
        sus  = int'(bus.sustain_level);
        rr   = int'(bus.release_rate);
        tick = (m_cnt == TICK_DIV - 1);
        rise = bus.gate && !m_gprev;
        fall = !bus.gate && m_gprev;
        p    = longint'(bus.wave_in) * longint'(m_lvl);
        nw   = int'(p >>> 16);
        ns   = m_state;
        nl   = m_lvl;
        nc   = tick ? 0 : m_cnt + 1;
        if (rise) begin
            ns = ST_ATTACK;
        end else if (fall) begin
            if (m_state == ST_ATTACK || m_state == ST_DECAY || m_state == ST_SUSTAIN) ns = ST_RELEASE;
        end else if (tick) begin
            case (m_state)
                ST_ATTACK: begin
                    nl = m_lvl + ar;
                    if (nl >= 65535) begin nl = 65535; ns = ST_DECAY; end
                end
                ST_DECAY: begin
                    nl = m_lvl - dr;
                    if (nl <= sus) begin nl = sus; ns = ST_SUSTAIN; end
                end
                ST_SUSTAIN: nl = sus;
                ST_RELEASE: begin
                    nl = m_lvl - rr;
                    if (nl <= 0) begin nl = 0; ns = ST_IDLE; end
                end
                default: nl = 0;
            endcase
        end
        ticked = tick && !rise && !fall && reset;
        if (!reset) begin
            ns = ST_IDLE; nl = 0; nc = 0; nw = 0;
        end
        @(posedge clk);
        m_state = ns;
        m_lvl   = nl;
        m_cnt   = nc;
        m_wave  = nw;
        m_gprev = reset ? bus.gate : 1'b0;
        #1;
        check("mdl_state", 16'(bus.env_state), 16'(m_state));
        check("mdl_level", bus.env_level, 16'(m_lvl));
        check("mdl_wave", bus.wave_out, 16'(m_wave));
    endtask

    task automatic step();
        bit t;
        cyc(t);
    endtask

    task automatic run_tick(input string name);
        bit t = 1'b0;
        for (int i = 0; i < TICK_DIV + 1; i++) if (!t) cyc(t);
        if (!t) bound_fail(name);
    endtask

    // Leaves the bench so the next edge is a prescaler tick.
    task automatic align_tick();
        for (int i = 0; i < TICK_DIV; i++) if (m_cnt != TICK_DIV - 1) step();
    endtask

    task automatic wait_state(input int st, input int max_clks, input string name);
        for (int i = 0; i < max_clks; i++) if (int'(bus.env_state) != st) step();
        if (int'(bus.env_state) != st) bound_fail(name);
    endtask

    task automatic expect_sl(input string name, input int st, input logic [15:0] lvl);
        check({name, " state"}, 16'(bus.env_state), 16'(st));
        check({name, " level"}, bus.env_level, lvl);
    endtask

    task automatic edge_to(input bit g);
        bus.gate = g;
        step();
    endtask

    function automatic logic [15:0] pick_rate();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2, 3:    return 16'($urandom_range(16'h0800, 16'h4000));
            default: return 16'($urandom_range(0, 16'hFFFF));
        endcase
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back('{OP_EDGE, 1'b1, 16'h4000, ST_ATTACK,  16'h0000, 16'h0000});
        tbl.push_back('{OP_TICK, 1'b1, 16'h4000, ST_ATTACK,  16'h4000, 16'h0000});
        tbl.push_back('{OP_TICK, 1'b1, 16'h4000, ST_ATTACK,  16'h8000, 16'h0000});
        tbl.push_back('{OP_TICK, 1'b1, 16'h4000, ST_ATTACK,  16'hC000, 16'h0000});
        tbl.push_back('{OP_TICK, 1'b1, 16'h4000, ST_DECAY,   16'hFFFF, 16'h0000});
        tbl.push_back('{OP_TICK, 1'b1, 16'h4000, ST_DECAY,   16'hEFFF, 16'h0000});
        tbl.push_back('{OP_TICK, 1'b1, 16'h4000, ST_DECAY,   16'hDFFF, 16'h0000});
        tbl.push_back('{OP_TICK, 1'b1, 16'h4000, ST_DECAY,   16'hCFFF, 16'h0000});
        tbl.push_back('{OP_TICK, 1'b1, 16'h4000, ST_DECAY,   16'hBFFF, 16'h0000});
        tbl.push_back('{OP_TICK, 1'b1, 16'h4000, ST_DECAY,   16'hAFFF, 16'h0000});
        tbl.push_back('{OP_TICK, 1'b1, 16'h4000, ST_DECAY,   16'h9FFF, 16'h0000});
        tbl.push_back('{OP_TICK, 1'b1, 16'h4000, ST_DECAY,   16'h8FFF, 16'h0000});
        tbl.push_back('{OP_TICK, 1'b1, 16'h4000, ST_SUSTAIN, 16'h8000, 16'h0000});
        tbl.push_back('{OP_TICK, 1'b1, 16'h4000, ST_SUSTAIN, 16'h8000, 16'h0000});
        tbl.push_back('{OP_WAVE, 1'b1, 16'h7FFF, ST_SUSTAIN, 16'h8000, 16'h3FFF});
        tbl.push_back('{OP_WAVE, 1'b1, 16'h8000, ST_SUSTAIN, 16'h8000, 16'hC000});
        tbl.push_back('{OP_WAVE, 1'b1, 16'h0000, ST_SUSTAIN, 16'h8000, 16'h0000});
        tbl.push_back('{OP_WAVE, 1'b1, 16'hFFFF, ST_SUSTAIN, 16'h8000, 16'hFFFF});
        tbl.push_back('{OP_WAVE, 1'b1, 16'h4000, ST_SUSTAIN, 16'h8000, 16'h2000});
        tbl.push_back('{OP_WAVE, 1'b1, 16'h0001, ST_SUSTAIN, 16'h8000, 16'h0000});
        tbl.push_back('{OP_EDGE, 1'b0, 16'h0000, ST_RELEASE, 16'h8000, 16'h0000});
        tbl.push_back('{OP_TICK, 1'b0, 16'h0000, ST_RELEASE, 16'h6000, 16'h0000});
        tbl.push_back('{OP_TICK, 1'b0, 16'h0000, ST_RELEASE, 16'h4000, 16'h0000});
        tbl.push_back('{OP_TICK, 1'b0, 16'h0000, ST_RELEASE, 16'h2000, 16'h0000});
        tbl.push_back('{OP_TICK, 1'b0, 16'h0000, ST_IDLE,    16'h0000, 16'h0000});
        tbl.push_back('{OP_TICK, 1'b0, 16'h0000, ST_IDLE,    16'h0000, 16'h0000});

        // Reset, then a quiet stretch with a live input sample.
        bus.gate          = 1'b0;
        bus.wave_in       = 16'sh4000;
        bus.attack_rate   = 16'h4000;
        bus.decay_rate    = 16'h1000;
        bus.sustain_level = 16'h8000;
        bus.release_rate  = 16'h2000;
        reset             = 1'b0;
        #1;
        step();
        step();
        expect_sl("reset", ST_IDLE, 16'h0000);
        check("reset wave", bus.wave_out, 16'h0000);
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            expect_sl("idle_hold", ST_IDLE, 16'h0000);
            check("idle_hold wave", bus.wave_out, 16'h0000);
        end

        // Full ADSR walk, scaling in sustain, release to idle.
        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_EDGE: edge_to(tbl[i].gate);
                OP_TICK: run_tick($sformatf("tbl[%0d] tick", i));
                OP_WAVE: begin
                    bus.wave_in = tbl[i].wave;
                    step();
                    check($sformatf("tbl[%0d] wave", i), bus.wave_out, tbl[i].wv);
                end
                default: ;
            endcase
            expect_sl($sformatf("tbl[%0d]", i), tbl[i].st, tbl[i].lvl);
        end

        // Legato retrigger from release at 0x6000, with the edge landing on a tick.
        bus.wave_in = 16'sh4000;
        edge_to(1'b1);
        wait_state(ST_SUSTAIN, 200, "retrig to sustain");
        edge_to(1'b0);
        expect_sl("retrig fall", ST_RELEASE, 16'h8000);
        run_tick("retrig rel");
        expect_sl("retrig rel", ST_RELEASE, 16'h6000);
        align_tick();
        edge_to(1'b1);
        expect_sl("retrig edge", ST_ATTACK, 16'h6000);
        run_tick("retrig attack");
        expect_sl("retrig attack", ST_ATTACK, 16'hA000);
        edge_to(1'b0);
        wait_state(ST_IDLE, 200, "retrig to idle");

        // Zero attack rate stalls; full sustain skips decay; full release rate ends in one tick.
        bus.attack_rate = 16'h0000;
        edge_to(1'b1);
        for (int i = 0; i < 50; i++) begin
            run_tick("stall tick");
            expect_sl("attack stall", ST_ATTACK, 16'h0000);
        end
        bus.attack_rate   = 16'h8000;
        bus.sustain_level = 16'hFFFF;
        run_tick("bnd a1");
        expect_sl("bnd a1", ST_ATTACK, 16'h8000);
        run_tick("bnd a2");
        expect_sl("bnd a2", ST_DECAY, 16'hFFFF);
        run_tick("bnd d1");
        expect_sl("bnd sus full", ST_SUSTAIN, 16'hFFFF);
        bus.release_rate = 16'hFFFF;
        edge_to(1'b0);
        expect_sl("bnd rel", ST_RELEASE, 16'hFFFF);
        run_tick("bnd r1");
        expect_sl("bnd rel fast", ST_IDLE, 16'h0000);

        // Reset while decaying at 0xC000, gate still held.
        bus.attack_rate   = 16'h4000;
        bus.decay_rate    = 16'h3FFF;
        bus.sustain_level = 16'h8000;
        bus.release_rate  = 16'h2000;
        edge_to(1'b1);
        for (int i = 0; i < 5; i++) run_tick("mid ramp");
        expect_sl("mid decay", ST_DECAY, 16'hC000);
        reset = 1'b0;
        step();
        expect_sl("mid reset", ST_IDLE, 16'h0000);
        check("mid reset wave", bus.wave_out, 16'h0000);
        reset = 1'b1;
        step();
        expect_sl("post reset", ST_ATTACK, 16'h0000);
        run_tick("post reset tick");
        expect_sl("post reset tick", ST_ATTACK, 16'h4000);

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.wave_in = 16'($urandom_range(0, 16'hFFFF));
            if ($urandom_range(0, 79) == 0) bus.gate = ~bus.gate;
            if ($urandom_range(0, 149) == 0) begin
                bus.attack_rate  = pick_rate();
                bus.decay_rate   = pick_rate();
                bus.release_rate = pick_rate();
            end
            if ($urandom_range(0, 59) == 0) bus.sustain_level = 16'($urandom_range(0, 16'hFFFF));
            reset = ($urandom_range(0, 399) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
